univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the team's fixed 4-bit serial-in/serial-out shifter. It supports hold, shift-right, shift-left and parallel load, with an optional rotate mode. A shift counter and a one-cycle word-done strobe let it act as a serializer or deserializer. It is the building block for the serial link and memory test datapaths.

---
 rtl/univ_shift_reg_pkg.sv | 19 +
 rtl/univ_shift_reg_shift_bit_counter.sv | 55 +++++
 rtl/univ_shift_reg.sv | 71 +++++++
 tb/tb_univ_shift_reg.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register and its counter.
// Mode encoding is fixed by the mode input port; helper sizes the shift counter.
package univ_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Counter needs at least one bit even for the degenerate width case.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_bit_counter.sv
// Modulo-MODULUS shift counter with synchronous clear and a registered
// one-cycle wrap strobe, shared by the serializer/deserializer datapaths.
module shift_bit_counter
  import univ_shift_reg_pkg::*;
#(
  parameter  int MODULUS = 8,
  localparam int CW      = cnt_width(MODULUS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  // Explicit terminal value so non-power-of-2 moduli never overflow naturally.
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise the untaken paths infer a latch.
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left (optionally
// rotating) and parallel load, with a word counter and word-done strobe.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  bit ROTATE = 1'b0,
  localparam int CW     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             word_done
);

  mode_e            op;
  logic [WIDTH-1:0] q_q, q_d;
  logic             msb_in, lsb_in;
  logic             shift, load;

  // en=0 collapses every mode to hold, which also clears word_done.
  assign op     = en ? mode_e'(mode) : MODE_HOLD;
  assign shift  = (op == MODE_SHR) || (op == MODE_SHL);
  assign load   = (op == MODE_LOAD);

  assign msb_in = ROTATE ? q_q[0]       : sin_r;
  assign lsb_in = ROTATE ? q_q[WIDTH-1] : sin_l;

  always_comb begin
    q_d = q_q;
    case (op)
      MODE_SHR:  q_d = {msb_in, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], lsb_in};
      MODE_LOAD: q_d = pin;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // A load restarts the word so partial progress is discarded.
  shift_bit_counter #(
    .MODULUS (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (shift),
    .clr_i  (load),
    .cnt_o  (cnt),
    .wrap_o (word_done)
  );

  assign pout   = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: four instances (W4, W8, W8 rotate, W5)
// checked against a behavioural model, plus directed spot values.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic clk;
  logic rst;

  logic        en_s   [4];
  logic [1:0]  mode_s [4];
  logic        sr_s   [4];
  logic        sl_s   [4];
  logic [63:0] pin_s  [4];

  logic [3:0] pout0;
  logic [7:0] pout1, pout2;
  logic [4:0] pout3;
  logic [1:0] cnt0;
  logic [2:0] cnt1, cnt2, cnt3;
  logic [3:0] wd_v, sor_v, sol_v;

  univ_shift_reg #(.WIDTH(4), .ROTATE(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .en(en_s[0]), .mode(mode_s[0]), .sin_r(sr_s[0]), .sin_l(sl_s[0]),
    .pin(pin_s[0][3:0]), .pout(pout0), .sout_r(sor_v[0]), .sout_l(sol_v[0]),
    .cnt(cnt0), .word_done(wd_v[0]));

  univ_shift_reg #(.WIDTH(8), .ROTATE(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .en(en_s[1]), .mode(mode_s[1]), .sin_r(sr_s[1]), .sin_l(sl_s[1]),
    .pin(pin_s[1][7:0]), .pout(pout1), .sout_r(sor_v[1]), .sout_l(sol_v[1]),
    .cnt(cnt1), .word_done(wd_v[1]));

  univ_shift_reg #(.WIDTH(8), .ROTATE(1'b1)) u_w8r (
    .clk(clk), .rst(rst), .en(en_s[2]), .mode(mode_s[2]), .sin_r(sr_s[2]), .sin_l(sl_s[2]),
    .pin(pin_s[2][7:0]), .pout(pout2), .sout_r(sor_v[2]), .sout_l(sol_v[2]),
    .cnt(cnt2), .word_done(wd_v[2]));

  univ_shift_reg #(.WIDTH(5), .ROTATE(1'b0)) u_w5 (
    .clk(clk), .rst(rst), .en(en_s[3]), .mode(mode_s[3]), .sin_r(sr_s[3]), .sin_l(sl_s[3]),
    .pin(pin_s[3][4:0]), .pout(pout3), .sout_r(sor_v[3]), .sout_l(sol_v[3]),
    .cnt(cnt3), .word_done(wd_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] q;
    int          cnt;
    bit          wd;
  } mstate_t;

  typedef struct {
    int          inst;
    string       tag;
    logic [63:0] q;
    int          cnt;
    bit          wd;
  } exp_t;

  mstate_t m [4];
  exp_t    sb[$];
  int      n_vec = 0;
  int      n_err = 0;

  function automatic int width_of(input int i);
    case (i)
      0:       return 4;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] obs_pout(input int i);
    case (i)
      0:       return 64'(pout0);
      1:       return 64'(pout1);
      2:       return 64'(pout2);
      default: return 64'(pout3);
    endcase
  endfunction

  function automatic logic [63:0] obs_cnt(input int i);
    case (i)
      0:       return 64'(cnt0);
      1:       return 64'(cnt1);
      2:       return 64'(cnt2);
      default: return 64'(cnt3);
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m[k] = '{q: 64'd0, cnt: 0, wd: 1'b0};
  endfunction

  function automatic void model_count(input int i);
    if (m[i].cnt == width_of(i) - 1) begin
      m[i].cnt = 0;
      m[i].wd  = 1'b1;
    end else begin
      m[i].cnt = m[i].cnt + 1;
      m[i].wd  = 1'b0;
    end
  endfunction

  function automatic void model_step(input int i, input bit e, input logic [1:0] md,
                                     input bit sr, input bit sl, input logic [63:0] p);
    int          w;
    bit          rot;
    logic [63:0] mask;
    logic [63:0] q;
    bit          in_bit;
    w    = width_of(i);
    rot  = (i == 2);
    mask = (64'd1 << w) - 64'd1;
    q    = m[i].q;
    if (!e || md == 2'b00) begin
      m[i].wd = 1'b0;
    end else if (md == 2'b01) begin
      in_bit  = rot ? q[0] : sr;
      m[i].q  = (q >> 1) | (64'(in_bit) << (w - 1));
      model_count(i);
    end else if (md == 2'b10) begin
      in_bit  = rot ? q[w-1] : sl;
      m[i].q  = ((q << 1) | 64'(in_bit)) & mask;
      model_count(i);
    end else begin
      m[i].q   = p & mask;
      m[i].cnt = 0;
      m[i].wd  = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    int   i;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    i = e.inst;
    check({e.tag, ".pout"},   obs_pout(i),      e.q);
    check({e.tag, ".cnt"},    obs_cnt(i),       64'(e.cnt));
    check({e.tag, ".wd"},     64'(wd_v[i]),     64'(e.wd));
    check({e.tag, ".sout_r"}, 64'(sor_v[i]),    64'(e.q[0]));
    check({e.tag, ".sout_l"}, 64'(sol_v[i]),    64'(e.q[width_of(i)-1]));
  endtask

  task automatic check_now(input int i, input string tag);
    sb.push_back('{inst: i, tag: tag, q: m[i].q, cnt: m[i].cnt, wd: m[i].wd});
    compare_front();
  endtask

  task automatic step(input int i, input bit e, input logic [1:0] md, input bit sr,
                      input bit sl, input logic [63:0] p, input string tag);
    for (int k = 0; k < 4; k++) begin
      en_s[k]   = (k == i) ? e : 1'b0;
      mode_s[k] = md;
      sr_s[k]   = sr;
      sl_s[k]   = sl;
      pin_s[k]  = p;
      model_step(k, (k == i) ? e : 1'b0, md, sr, sl, p);
    end
    sb.push_back('{inst: i, tag: tag, q: m[i].q, cnt: m[i].cnt, wd: m[i].wd});
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    logic [63:0] bits;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      en_s[k] = 1'b0; mode_s[k] = 2'b00; sr_s[k] = 1'b0; sl_s[k] = 1'b0; pin_s[k] = '0;
    end
    model_reset();
    #12;
    for (int k = 0; k < 4; k++) check_now(k, "reset");
    rst = 1'b0;

    // W5: continuous shifting straight out of reset, pulses every 5 shifts.
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      step(3, 1'b1, (n % 3 == 2) ? 2'b10 : 2'b01, n[0], ~n[0], '0, "w5_run");
      if (wd_v[3]) pulses++;
    end
    check("w5_pulses", 64'(pulses), 64'd3);

    // W4 legacy right-shifter fill.
    bits = 64'b1101;
    for (int n = 0; n < 4; n++) step(0, 1'b1, 2'b01, bits[n], 1'b0, '0, "w4_fill");
    check("w4_fill_value", 64'(pout0), 64'hD);
    step(0, 1'b1, 2'b01, 1'b0, 1'b0, '0, "w4_next");

    // W8: load A5 and shift it out to the left.
    step(1, 1'b1, 2'b11, 1'b0, 1'b0, 64'hA5, "w8_load");
    for (int n = 0; n < 8; n++) step(1, 1'b1, 2'b10, 1'b0, 1'b0, '0, "w8_shl");
    check("w8_empty", 64'(pout1), 64'h0);
    step(1, 1'b1, 2'b00, 1'b0, 1'b0, '0, "w8_hold");

    // W8 rotate.
    step(2, 1'b1, 2'b11, 1'b0, 1'b0, 64'h81, "rot_load");
    for (int n = 0; n < 3; n++) step(2, 1'b1, 2'b01, 1'b1, 1'b1, '0, "rot_shr");
    check("rot_three", 64'(pout2), 64'h30);
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      step(2, 1'b1, 2'b01, 1'b1, 1'b1, '0, "rot_shr");
      if (wd_v[2]) pulses++;
    end
    check("rot_full", 64'(pout2), 64'h81);
    check("rot_pulses", 64'(pulses), 64'd1);

    // Load mid-word, then an en=0 freeze mid-word.
    for (int n = 0; n < 3; n++) step(1, 1'b1, 2'b01, 1'b1, 1'b0, '0, "mid_shr");
    step(1, 1'b1, 2'b11, 1'b0, 1'b0, 64'h3C, "mid_load");
    for (int n = 0; n < 3; n++) step(1, 1'b1, 2'b10, 1'b1, 1'b1, '0, "mid_shl");
    for (int n = 0; n < 4; n++) step(1, 1'b0, 2'b01, 1'b1, 1'b1, 64'hFF, "freeze");
    for (int n = 0; n < 5; n++) step(1, 1'b1, 2'b01, 1'b0, 1'b0, '0, "resume");

    // Async reset between edges with pout=5A, cnt=4.
    step(1, 1'b1, 2'b11, 1'b0, 1'b0, 64'hA5, "ar_load");
    bits = 64'b0101;
    for (int n = 0; n < 4; n++) step(1, 1'b1, 2'b10, 1'b0, bits[n], '0, "ar_shl");
    check("ar_pre_pout", 64'(pout1), 64'h5A);
    check("ar_pre_cnt", 64'(cnt1), 64'd4);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) check_now(k, "async_rst");
    en_s[1] = 1'b1; mode_s[1] = 2'b11; pin_s[1] = 64'hFF;
    @(posedge clk);
    #1;
    check_now(1, "rst_held");
    en_s[1] = 1'b0;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) step(1, 1'b1, 2'b01, n[1], 1'b0, '0, "post_rst");
    step(1, 1'b1, 2'b01, 1'b1, 1'b0, '0, "post_rst");

    for (int n = 0; n < 300; n++) begin
      step($urandom_range(3), ($urandom_range(7) != 0), 2'($urandom_range(3)),
           1'($urandom), 1'($urandom), {$urandom, $urandom}, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
